shared_add_arbiter: RTL and testbench

Round-robin arbiter and result register for a single shared signed 32-bit adder in the pipelined MIPS core. Up to four requesters (e.g. EX-stage ALU add, branch-target add, load/store address add, multi-cycle unit) present operand pairs with valid/ready handshakes. One request is granted per cycle, summed, and returned one cycle later with the requester's ID and a signed-overflow flag. It sits beside the EX stage and replaces per-client adders.

---
 rtl/shared_add_arbiter_if.sv | 61 ++++++
 rtl/shared_add_arbiter.sv | 127 ++++++++++++
 tb/tb_shared_add_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_add_arbiter_if.sv
// ---------------------------------------------------------------------------
// shared_add_arbiter_if
//
// Request/response bundle between up to four adder clients and the shared
// adder arbiter.
//
//   req_valid  [N_REQ]        per-requester request valid
//   req_ready  [N_REQ]        per-requester grant, one-hot or zero
//   req_a      [N_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      [N_REQ*WIDTH]  operand B, same packing
//   rsp_valid                 result register holds an unconsumed result
//   rsp_ready                 consumer accepts the result
//   rsp_id     [2]            requester that produced the result
//   rsp_sum    [WIDTH]        a + b, low WIDTH bits
//   rsp_ovf                   signed overflow of that add
//
// Modports:
//   master - the client side (requesters plus result consumer)
//   slave  - the arbiter
// ---------------------------------------------------------------------------
interface shared_add_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_REQ = 4
);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_ovf;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_sum,
        input  rsp_ovf
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_sum,
        output rsp_ovf
    );

endinterface

// File: rtl/shared_add_arbiter.sv
// ---------------------------------------------------------------------------
// shared_add_arbiter
//
// Round-robin arbiter in front of one shared signed WIDTH-bit adder. Each
// cycle at most one requester is granted; its operands are added and the
// sum, requester ID and signed-overflow flag are registered into a one-entry
// result buffer that is presented on the response side in the next cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shared_add_arbiter_if.slave (request and response handshakes)
// ---------------------------------------------------------------------------
module shared_add_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_add_arbiter_if.slave  bus
);

    localparam int unsigned NReq = 4;

    // Round-robin pointer and result register.
    logic [1:0]       ptr_q,       ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
    logic             rsp_ovf_q,   rsp_ovf_d;

    // Arbitration and datapath.
    logic             can_accept;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic [1:0]       scan_idx;
    logic [NReq-1:0]  grant_oh;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    // The result slot is free if empty or being drained this cycle, which
    // gives full throughput with a single output register.
    assign can_accept = !rsp_valid_q || bus.rsp_ready;

    // Scan requesters starting at ptr_q; the first valid one wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (can_accept) begin
            for (int unsigned k = 0; k < NReq; k++) begin
                scan_idx = ptr_q + 2'(k);
                if (!grant_vld && bus.req_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NReq; i++) begin
            if (grant_idx == 2'(i)) begin
                a_sel = bus.req_a[i*WIDTH +: WIDTH];
                b_sel = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Signed overflow: operands agree in sign but the sum does not.
    assign sum = a_sel + b_sel;
    assign ovf = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);

    // Next-state for pointer and result register.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_ovf_d   = rsp_ovf_q;
        if (grant_vld) begin
            // A new result overwrites the slot even if it is being drained.
            ptr_d       = grant_idx + 2'd1;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_sum_d   = sum;
            rsp_ovf_d   = ovf;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            // Drain only; the data fields keep their last values.
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_shared_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_add_arbiter
//
// Self-checking bench for shared_add_arbiter. A negedge monitor keeps its own
// model of the round-robin pointer and result slot, predicts req_ready, pushes
// an expected result whenever a grant is predicted and pops/compares it when
// the result is consumed. Directed sequences cover the listed scenarios; a
// short random phase follows.
// ---------------------------------------------------------------------------
module tb_shared_add_arbiter;

    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    shared_add_arbiter_if #(.WIDTH(W), .N_REQ(4)) bus ();

    shared_add_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] sum;
        logic         ovf;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference add: overflow from the exact signed sum being out of range.
    function automatic rsp_t model_add(input logic [1:0] id, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        rsp_t   r;
        longint s;
        s     = longint'($signed(a)) + longint'($signed(b));
        r.id  = id;
        r.sum = a + b;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return r;
    endfunction

    // ---------------- Monitor / scoreboard ----------------
    logic [1:0]   m_ptr;
    logic         m_valid;
    logic         hold_chk;
    logic [1:0]   h_id;
    logic [W-1:0] h_sum;
    logic         h_ovf;
    logic [3:0]   mon_rdy;
    logic [1:0]   mon_g;
    logic [1:0]   mon_idx;
    logic         mon_acc;
    rsp_t         mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            m_ptr    = '0;
            m_valid  = 1'b0;
            hold_chk = 1'b0;
        end else begin
            check_eq("mon_rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
            if (hold_chk) begin
                check_eq("hold_id", 64'(bus.rsp_id), 64'(h_id));
                check_eq("hold_sum", 64'(bus.rsp_sum), 64'(h_sum));
                check_eq("hold_ovf", 64'(bus.rsp_ovf), 64'(h_ovf));
            end
            mon_acc = !m_valid || bus.rsp_ready;
            mon_rdy = '0;
            mon_g   = '0;
            if (mon_acc) begin
                for (int k = 0; k < 4; k++) begin
                    mon_idx = m_ptr + 2'(k);
                    if (mon_rdy == '0 && bus.req_valid[mon_idx]) begin
                        mon_rdy[mon_idx] = 1'b1;
                        mon_g            = mon_idx;
                    end
                end
            end
            check_eq("mon_req_ready", 64'(bus.req_ready), 64'(mon_rdy));
            if (m_valid && bus.rsp_ready) begin
                check_eq("sb_size", 64'(sb_q.size()), 64'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check_eq("sb_id", 64'(bus.rsp_id), 64'(mon_e.id));
                    check_eq("sb_sum", 64'(bus.rsp_sum), 64'(mon_e.sum));
                    check_eq("sb_ovf", 64'(bus.rsp_ovf), 64'(mon_e.ovf));
                end
            end
            hold_chk = m_valid && !bus.rsp_ready;
            h_id     = bus.rsp_id;
            h_sum    = bus.rsp_sum;
            h_ovf    = bus.rsp_ovf;
            if (mon_rdy != '0) begin
                sb_q.push_back(model_add(mon_g, bus.req_a[mon_g*W +: W], bus.req_b[mon_g*W +: W]));
                m_ptr   = mon_g + 2'd1;
                m_valid = 1'b1;
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    // One request from requester i alone, rsp_ready assumed high.
    task automatic do_single(input string tag, input int i, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] es, input logic eo);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        set_op(i, a, b);
        bus.req_valid = oh;
        @(negedge clk);
        check_eq({tag, "_rdy"}, 64'(bus.req_ready), 64'(oh));
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check_eq({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
        check_eq({tag, "_id"}, 64'(bus.rsp_id), 64'(i));
        check_eq({tag, "_sum"}, 64'(bus.rsp_sum), 64'(es));
        check_eq({tag, "_ovf"}, 64'(bus.rsp_ovf), 64'(eo));
        tick();
    endtask

    function automatic logic [W-1:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- Main sequence ----------------
    initial begin
        logic [3:0] hold;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_sum", 64'(bus.rsp_sum), 64'd0);
        check_eq("rst_id", 64'(bus.rsp_id), 64'd0);
        check_eq("rst_ovf", 64'(bus.rsp_ovf), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic add, ptr -> 1
        do_single("basic", 0, 32'd5, 32'd7, 32'd12, 1'b0);
        // Grant 3 alone so ptr returns to 0
        do_single("p3", 3, 32'd1, 32'd2, 32'd3, 1'b0);

        // All four valid: strict 0,1,2,3 rotation, result one cycle later
        for (int i = 0; i < 4; i++) set_op(i, 32'(100 * i), 32'(i));
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                check_eq("rr_valid", 64'(bus.rsp_valid), 64'd1);
                check_eq("rr_id", 64'(bus.rsp_id), 64'((k - 1) % 4));
            end
            tick();
        end
        bus.req_valid = '0;
        @(negedge clk);
        check_eq("rr_last_id", 64'(bus.rsp_id), 64'd3);
        check_eq("rr_last_sum", 64'(bus.rsp_sum), 64'd303);
        tick();

        // Overflow corners (ptr = 0)
        do_single("ovf_pos", 0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
        do_single("ovf_neg", 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        do_single("no_ovf", 0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);

        // Back-pressure: result from requester 0 held, ptr = 1
        bus.rsp_ready = 1'b0;
        set_op(0, 32'd10, 32'd20);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check_eq("bp_first_rdy", 64'(bus.req_ready), 64'b0001);
        tick();
        set_op(1, 32'd1000, 32'd1);
        set_op(3, 32'd3000, 32'd3);
        bus.req_valid = 4'b1010;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_rdy", 64'(bus.req_ready), 64'd0);
            check_eq("bp_valid", 64'(bus.rsp_valid), 64'd1);
            check_eq("bp_sum", 64'(bus.rsp_sum), 64'd30);
            check_eq("bp_id", 64'(bus.rsp_id), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_rdy", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check_eq("bp_next_id", 64'(bus.rsp_id), 64'd1);
        check_eq("bp_next_sum", 64'(bus.rsp_sum), 64'd1001);
        tick();

        // Wrap-around: ptr -> 3, then only requester 0
        do_single("to3", 2, 32'd4, 32'd4, 32'd8, 1'b0);
        set_op(0, 32'd50, 32'd50);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check_eq("wrap_rdy", 64'(bus.req_ready), 64'b0001);
        tick();
        // ptr is now 1: with 0 and 3 valid, 3 comes first
        set_op(3, 32'd9, 32'd9);
        bus.req_valid = 4'b1001;
        @(negedge clk);
        check_eq("wrap_ptr1", 64'(bus.req_ready), 64'b1000);
        tick();
        bus.req_valid = '0;
        tick();

        // Mid-cycle reset with a pending result and ptr = 2
        set_op(1, 32'd77, 32'd1);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check_eq("pre_rst_rdy", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("mrst_sum", 64'(bus.rsp_sum), 64'd0);
        check_eq("mrst_id", 64'(bus.rsp_id), 64'd0);
        check_eq("mrst_ovf", 64'(bus.rsp_ovf), 64'd0);
        tick();
        set_op(2, 32'd20, 32'd2);
        set_op(3, 32'd30, 32'd3);
        bus.req_valid = 4'b1100;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rdy", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check_eq("post_rst_id", 64'(bus.rsp_id), 64'd2);
        tick();

        // Random phase; pending requesters hold their operands
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            hold = bus.req_valid & ~bus.req_ready;
            tick();
            for (int i = 0; i < 4; i++) begin
                if (!hold[i]) begin
                    bus.req_valid[i] = 1'($urandom_range(0, 1));
                    set_op(i, pick_op(), pick_op());
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
